// File: rtl/sort_pkg.sv
// Shared definitions for the bubble-sort engine and its drain stage.
package sort_pkg;

    localparam int NUM_ITEMS = 10;
    localparam int DATA_W    = 16;
    localparam int IDX_W     = 4;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // A stream step is out of order only when it is not the first word and drops below its predecessor.
    function automatic logic is_descent(input word_t cur, input word_t prev, input logic first);
        return !first && (cur < prev);
    endfunction

endpackage

// File: rtl/sort_drain.sv
// Drain stage: snapshots the sorter result bank on a done edge, streams it out
// over valid/ready and flags any descending step in the stream.
module sort_drain
    import sort_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sort_done,
    input  logic [NUM_ITEMS*DATA_W-1:0] dat_in,
    output logic                        rd_en,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        order_err,
    output logic                        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ITEMS - 1);

    state_t           state;
    logic             done_q;
    logic             first;
    logic [IDX_W-1:0] idx;
    word_t            prev;
    word_t            bank [NUM_ITEMS];

    logic done_rise;
    logic xfer;

    assign done_rise = sort_done & ~done_q;
    assign out_valid = (state == STREAM);
    assign busy      = (state != IDLE);
    assign out_data  = out_valid ? bank[idx] : '0;
    assign out_idx   = idx;
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign xfer      = out_valid & out_ready;

    // Edges arriving while streaming are dropped; done_q still tracks the level
    // so a done held high after the last word cannot retrigger a capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            done_q    <= 1'b0;
            first     <= 1'b1;
            idx       <= '0;
            prev      <= '0;
            order_err <= 1'b0;
            rd_en     <= 1'b0;
            for (int k = 0; k < NUM_ITEMS; k++) begin
                bank[k] <= '0;
            end
        end else begin
            done_q <= sort_done;
            rd_en  <= 1'b0;
            if (state == IDLE) begin
                if (done_rise) begin
                    for (int k = 0; k < NUM_ITEMS; k++) begin
                        bank[k] <= dat_in[k*DATA_W +: DATA_W];
                    end
                    order_err <= 1'b0;
                    prev      <= '0;
                    idx       <= '0;
                    first     <= 1'b1;
                    rd_en     <= 1'b1;
                    state     <= STREAM;
                end
            end else if (xfer) begin
                if (is_descent(out_data, prev, first)) begin
                    order_err <= 1'b1;
                end
                prev  <= out_data;
                first <= 1'b0;
                if (out_last) begin
                    idx   <= '0;
                    state <= IDLE;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_drain.sv
// Directed bench for sort_drain: capture, streaming, backpressure, order check,
// re-arm behaviour and asynchronous reset.
module tb_sort_drain;
    import sort_pkg::*;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        sort_done;
    logic [NUM_ITEMS*DATA_W-1:0] dat_in;
    logic                        rd_en;
    logic                        out_valid;
    logic                        out_ready;
    logic [DATA_W-1:0]           out_data;
    logic [IDX_W-1:0]            out_idx;
    logic                        out_last;
    logic                        order_err;
    logic                        busy;

    int    n_pass  = 0;
    int    n_total = 0;
    word_t exp_w [NUM_ITEMS];

    sort_drain dut (
        .clk       (clk),
        .reset     (reset),
        .sort_done (sort_done),
        .dat_in    (dat_in),
        .rd_en     (rd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .order_err (order_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic load_bank();
        for (int k = 0; k < NUM_ITEMS; k++) begin
            dat_in[k*DATA_W +: DATA_W] = exp_w[k];
        end
    endtask

    // Produce a fresh rising edge; returns at T+1 (the first streamed cycle).
    task automatic fresh_edge();
        sort_done = 1'b0;
        tick();
        sort_done = 1'b1;
        tick();
    endtask

    // Stream with out_ready high from T+1; err_from is the first cycle index at which order_err is expected.
    task automatic stream_check(input string name, input int err_from);
        for (int i = 0; i < NUM_ITEMS; i++) begin
            chk($sformatf("%s_valid%0d", name, i), out_valid, 1);
            chk($sformatf("%s_data%0d", name, i), out_data, exp_w[i]);
            chk($sformatf("%s_idx%0d", name, i), out_idx, i);
            chk($sformatf("%s_last%0d", name, i), out_last, (i == NUM_ITEMS-1));
            chk($sformatf("%s_rden%0d", name, i), rd_en, (i == 0));
            chk($sformatf("%s_err%0d", name, i), order_err, (i >= err_from));
            tick();
        end
        chk({name, "_end_busy"}, busy, 0);
        chk({name, "_end_valid"}, out_valid, 0);
        chk({name, "_end_err"}, order_err, (err_from < NUM_ITEMS));
    endtask

    initial begin
        reset     = 1'b1;
        sort_done = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < NUM_ITEMS; k++) exp_w[k] = word_t'(k + 1);
        load_bank();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rden", rd_en, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data", out_data, 0);
        chk("idle_idx", out_idx, 0);
        chk("idle_last", out_last, 0);
        chk("idle_err", order_err, 0);
        chk("idle_rden", rd_en, 0);

        // Basic ascending stream
        sort_done = 1'b1;
        tick();
        stream_check("basic", NUM_ITEMS);

        // Done held high: no second capture
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("held_busy%0d", c), busy, 0);
            chk($sformatf("held_rden%0d", c), rd_en, 0);
            tick();
        end

        // Backpressure with ready pattern 1,0,0,1,0,0,...
        fresh_edge();
        begin
            int e = 0;
            for (int c = 0; c < 40 && e < NUM_ITEMS; c++) begin
                out_ready = ((c % 3) == 0);
                chk($sformatf("bp_valid_c%0d", c), out_valid, 1);
                chk($sformatf("bp_data_c%0d", c), out_data, exp_w[e]);
                chk($sformatf("bp_idx_c%0d", c), out_idx, e);
                chk($sformatf("bp_last_c%0d", c), out_last, (e == NUM_ITEMS-1));
                if (out_ready) e++;
                tick();
            end
            chk("bp_count", e, NUM_ITEMS);
        end
        out_ready = 1'b1;
        chk("bp_end_busy", busy, 0);
        chk("bp_end_err", order_err, 0);

        // Order error: 3,5,4,6..12; a done edge mid-stream must be ignored
        exp_w[0] = 16'd3;
        exp_w[1] = 16'd5;
        exp_w[2] = 16'd4;
        for (int k = 3; k < NUM_ITEMS; k++) exp_w[k] = word_t'(k + 3);
        load_bank();
        fresh_edge();
        sort_done = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (i == 2) sort_done = 1'b1;
            chk($sformatf("oe_data%0d", i), out_data, exp_w[i]);
            chk($sformatf("oe_err%0d", i), order_err, (i >= 3));
            chk($sformatf("oe_rden%0d", i), rd_en, (i == 0));
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("oe_after_busy%0d", c), busy, 0);
            chk($sformatf("oe_after_err%0d", c), order_err, 1);
            tick();
        end

        // Re-arm with equal words: order_err clears on capture and stays low
        for (int k = 0; k < NUM_ITEMS; k++) exp_w[k] = 16'h7FFF;
        load_bank();
        fresh_edge();
        stream_check("eq", NUM_ITEMS);

        // Mid-stream reset after word 4, with an ignored done edge beforehand
        for (int k = 0; k < NUM_ITEMS; k++) exp_w[k] = word_t'(k + 1);
        load_bank();
        fresh_edge();
        for (int i = 0; i < 4; i++) begin
            if (i == 1) sort_done = 1'b0;
            if (i == 2) sort_done = 1'b1;
            chk($sformatf("mr_data%0d", i), out_data, exp_w[i]);
            chk($sformatf("mr_rden%0d", i), rd_en, (i == 0));
            tick();
        end
        chk("mr_pre_idx", out_idx, 4);
        reset = 1'b1;
        #1;
        chk("mr_rst_valid", out_valid, 0);
        chk("mr_rst_busy", busy, 0);
        chk("mr_rst_data", out_data, 0);
        chk("mr_rst_idx", out_idx, 0);
        chk("mr_rst_last", out_last, 0);
        chk("mr_rst_rden", rd_en, 0);
        tick();
        chk("mr_rst_hold_busy", busy, 0);
        // done still high at reset release counts as a fresh rising edge
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("mr_restart_valid", out_valid, 1);
        chk("mr_restart_idx", out_idx, 0);
        chk("mr_restart_data", out_data, 1);
        chk("mr_restart_rden", rd_en, 1);
        tick();
        chk("mr_second_idx", out_idx, 1);
        chk("mr_second_rden", rd_en, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
